// File: rtl/instruction_fetch.sv
// Instruction-fetch stage: PC, imem req/ack master, {PC+4, instr} slot feeding IF/ID.
// Latency: ack in cycle t presents the instruction in t+1; zero-wait memory sustains one per cycle.
// Backpressure: pc_write=0 holds the slot; one extra ack is parked in a skid entry and requests pause.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pc_write,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] fetch_pc,
    output logic [31:0] fetch_instruction,
    output logic        fetch_flush,
    output logic        addr_err
);

    // FETCH issues requests, HOLD waits with slot+skid full, DRAIN retires a
    // request made stale by a redirect before jumping to the saved target.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] slot_instr_q, slot_instr_d;
    logic [31:0] slot_pc4_q, slot_pc4_d;
    logic        slot_vld_q, slot_vld_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic [31:0] skid_pc4_q, skid_pc4_d;
    logic        skid_vld_q, skid_vld_d;
    logic [31:0] target_q, target_d;
    logic        addr_err_q, addr_err_d;

    logic        ack;
    logic        consume;
    logic [31:0] pc_plus4;
    logic [31:0] redirect_tgt;

    // Requests pause only in HOLD; the memory is never asked while in reset.
    assign imem_req          = ~rst & (state_q != HOLD);
    assign imem_addr         = pc_q;
    assign fetch_pc          = slot_pc4_q;
    assign fetch_instruction = slot_instr_q;
    assign fetch_flush       = ~slot_vld_q;
    assign addr_err          = addr_err_q;

    // An ack only counts against a live request, so a stray ack in HOLD is ignored.
    assign ack          = imem_ack & imem_req;
    assign consume      = slot_vld_q & pc_write;
    assign pc_plus4     = pc_q + 32'd4;
    assign redirect_tgt = {redirect_pc[31:2], 2'b00};

    // Next-state: redirect overrides everything, otherwise per-state fetch/stall handling.
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        slot_instr_d = slot_instr_q;
        slot_pc4_d   = slot_pc4_q;
        slot_vld_d   = slot_vld_q;
        skid_instr_d = skid_instr_q;
        skid_pc4_d   = skid_pc4_q;
        skid_vld_d   = skid_vld_q;
        target_d     = target_q;
        addr_err_d   = addr_err_q;

        if (redirect_valid) begin
            // No delay slots: whatever is presented or parked is squashed.
            slot_vld_d = 1'b0;
            skid_vld_d = 1'b0;
            if (redirect_pc[1:0] != 2'b00) begin
                addr_err_d = 1'b1;
            end
            case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d    = redirect_tgt;
                        state_d = FETCH;
                    end else begin
                        // Address must stay stable until the pending request completes.
                        target_d = redirect_tgt;
                        state_d  = DRAIN;
                    end
                end
                HOLD: begin
                    pc_d    = redirect_tgt;
                    state_d = FETCH;
                end
                DRAIN: begin
                    target_d = redirect_tgt;
                    if (ack) begin
                        pc_d    = redirect_tgt;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end else begin
            case (state_q)
                FETCH: begin
                    if (ack) begin
                        pc_d = pc_plus4;
                        if (!slot_vld_q || consume) begin
                            slot_instr_d = imem_rdata;
                            slot_pc4_d   = pc_plus4;
                            slot_vld_d   = 1'b1;
                        end else begin
                            skid_instr_d = imem_rdata;
                            skid_pc4_d   = pc_plus4;
                            skid_vld_d   = 1'b1;
                            state_d      = HOLD;
                        end
                    end else if (consume) begin
                        slot_vld_d = 1'b0;
                    end
                end
                HOLD: begin
                    if (pc_write) begin
                        slot_instr_d = skid_instr_q;
                        slot_pc4_d   = skid_pc4_q;
                        slot_vld_d   = skid_vld_q;
                        skid_vld_d   = 1'b0;
                        state_d      = FETCH;
                    end
                end
                DRAIN: begin
                    // Returned word belongs to the wrong path and is dropped.
                    if (ack) begin
                        pc_d    = target_q;
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State register with synchronous reset; outstanding requests are abandoned.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            slot_instr_q <= 32'd0;
            slot_pc4_q   <= 32'd0;
            slot_vld_q   <= 1'b0;
            skid_instr_q <= 32'd0;
            skid_pc4_q   <= 32'd0;
            skid_vld_q   <= 1'b0;
            target_q     <= 32'd0;
            addr_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            slot_instr_q <= slot_instr_d;
            slot_pc4_q   <= slot_pc4_d;
            slot_vld_q   <= slot_vld_d;
            skid_instr_q <= skid_instr_d;
            skid_pc4_q   <= skid_pc4_d;
            skid_vld_q   <= skid_vld_d;
            target_q     <= target_d;
            addr_err_q   <= addr_err_d;
        end
    end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Instruction-fetch stage of the 5-stage MIPS pipeline. It holds the program counter, issues word requests to instruction memory over a req/ack handshake and presents {PC+4, instruction} to the IF/ID pipeline register. It absorbs hazard stalls with a one-entry skid buffer and handles branch/jump redirects from later stages. fetch_flush drives the IF/ID register's flush input, which inserts a bubble.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- pc_write  in  1  1 = decode consumes the presented instruction this cycle; 0 = stall, hold the output
- redirect_valid  in  1  single-cycle pulse, taken branch or jump
- redirect_pc  in  32  redirect target
- imem_req  out  1  memory request; once raised, held with stable imem_addr until imem_ack
- imem_addr  out  32  word address of the request
- imem_ack  in  1  request completed; imem_rdata valid in the same cycle
- imem_rdata  in  32  instruction word
- fetch_pc  out  32  PC+4 of the presented instruction (to IF/ID in_pc)
- fetch_instruction  out  32  presented instruction (to IF/ID in_instruction)
- fetch_flush  out  1  1 = no valid instruction presented (to IF/ID flush)
- addr_err  out  1  sticky, set by a misaligned redirect target

## Operation
- State: pc, output slot (instr, pc+4, valid), skid slot (instr, pc+4, valid), redirect target register, and an FSM with states FETCH, HOLD and DRAIN.
- fetch_flush = ~slot.valid. The slot is consumed in any cycle where slot.valid & pc_write.
- FETCH: imem_req=1, imem_addr=pc.
  - On ack: pc <= pc+4.
  - Data goes to the slot if the slot is empty or is being consumed.
  - Otherwise data goes to skid, and the FSM moves to HOLD.
- FETCH without ack: a consumed slot becomes empty.
- HOLD: imem_req=0. The slot and skid are both valid. On pc_write=1: slot <= skid, skid cleared, FSM moves to FETCH.
- DRAIN: imem_req=1 with the old address. The ack data is discarded. On ack: pc <= target, FSM moves to FETCH.
- redirect_valid has priority over everything else:
  - Slot and skid are invalidated; fetch_flush=1 in the next cycle.
  - In FETCH with ack this cycle, or in HOLD: pc <= target, next state FETCH. The ack data is dropped.
  - In FETCH without ack: target is latched, next state DRAIN.
  - In DRAIN: target is overwritten (last redirect wins). If ack arrives in the same cycle, pc <= new target and the FSM moves to FETCH.
- Target = {redirect_pc[31:2], 2'b00}. If redirect_pc[1:0] != 0, addr_err <= 1 and stays set until rst.
- PC arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0 with no error.
- There are no branch delay slots. The instruction presented in the redirect cycle is flushed.

## Timing
- Reset values:
  - imem_req=0 while rst=1; imem_addr=RESET_PC.
  - fetch_flush=1, fetch_pc=0, fetch_instruction=0, addr_err=0.
  - FSM=FETCH, slot and skid invalid.
- First request: the first cycle after rst falls, at addr=RESET_PC.
- Latency: ack in cycle t leads to fetch_instruction and fetch_pc valid with fetch_flush=0 in cycle t+1.
- Throughput: with a zero-wait memory (ack in the request cycle), one instruction per cycle, with addresses N, N+4, … on consecutive cycles.
- Redirect in cycle t (no outstanding request) leads to imem_addr=target in t+1 and the target instruction presented in t+2 with zero-wait memory.
- Stall: the outputs stay bit-stable while pc_write=0. No instruction is lost or duplicated across any stall length.
- Reset mid-operation: any outstanding request is abandoned. All state returns to the reset values in the next cycle.

## Test plan
- Reset, then zero-wait memory with rdata = addr ^ 32'hA5A5_A5A5 → imem_addr 0,4,8,… on consecutive cycles; fetch_pc 4,8,12,… one cycle later; fetch_flush=0 from the second cycle after reset.
- Memory with a 3-cycle ack delay → imem_addr held stable for 3 cycles; fetch_flush=1 between instructions; fetch_pc increments by 4 per delivered instruction.
- pc_write=0 for 4 cycles during streaming → the output is held; the next ack goes to skid, and imem_req drops in HOLD. Resume → the held instruction, then the skid instruction, then addr+8, with no gaps or duplicates.
- redirect_valid with redirect_pc=32'h100 while a request at 32'h20 is outstanding (ack 2 cycles later) → imem_addr stays 32'h20 until ack; that data is dropped; the next imem_addr is 32'h100; the first delivered fetch_pc is 32'h104.
- redirect_pc=32'h102 → imem_addr=32'h100 and addr_err=1, and addr_err stays 1 until rst. Redirect at pc=32'hFFFF_FFFC → the next address is 0.
- Assert rst for 1 cycle during HOLD with skid valid → all outputs return to the reset values and fetching restarts at RESET_PC.
